// File: rtl/pipeline_stall_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller_pkg
// Shared definitions for the pipeline stall controller slice:
//   - FSM state encoding (RUN=0, MEM_WAIT=1, ERROR=2)
//   - default memory timeout and performance counter width
// ---------------------------------------------------------------------------
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } psc_state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 255;
    localparam int COUNT_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/pipeline_stall_controller_counter.sv
// ---------------------------------------------------------------------------
// saturating_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clock     - rising-edge clock
//   reset     - asynchronous active-high clear
//   increment - count up by one this cycle (ignored once saturated)
//   count     - current count value, WIDTH bits
// ---------------------------------------------------------------------------
module saturating_counter
    import pipeline_stall_controller_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             increment,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (increment && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
// Central stall/flush controller for a 5-stage pipeline. Combines load-use
// hazard stalls, taken-branch flushes and data-memory wait freezes into the
// per-register enable/flush controls, tracks memory wait time with a
// timeout into a sticky error state, and keeps two saturating performance
// counters.
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-high reset
//   stall               - load-use hazard request
//   EX_branch_taken     - branch/jump resolved taken in EX
//   MEM_request         - MEM stage issues a load/store this cycle
//   MEM_ready           - data memory completes the access this cycle
//   PC_enable           - program counter may update
//   IF_ID/ID_EX/EX_MEM/MEM_WB_enable - pipeline register may load
//   IF_ID_flush, ID_EX_flush         - pipeline register loads a bubble
//   error               - memory timeout seen, sticky until reset
//   stall_cycles        - cycles with PC_enable low (saturating)
//   flush_events        - taken-branch flushes applied (saturating)
// ---------------------------------------------------------------------------
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   EX_branch_taken,
    input  logic                   MEM_request,
    input  logic                   MEM_ready,
    output logic                   PC_enable,
    output logic                   IF_ID_enable,
    output logic                   ID_EX_enable,
    output logic                   EX_MEM_enable,
    output logic                   MEM_WB_enable,
    output logic                   IF_ID_flush,
    output logic                   ID_EX_flush,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] stall_cycles,
    output logic [COUNT_WIDTH-1:0] flush_events
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    psc_state_t        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              freeze;
    logic              branch_applied;

    // State, wait counter and sticky error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            // Registered from the current state, so error rises the cycle
            // after ERROR is entered.
            error    <= error | (state == ERROR);
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (MEM_request && !MEM_ready) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            MEM_WAIT: begin
                if (MEM_ready) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                    state_nxt = ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // The ready cycle inside MEM_WAIT is not a freeze, so it decodes exactly
    // like a RUN cycle and the access completes with no extra bubble.
    assign freeze = ((state == RUN) && MEM_request && !MEM_ready) ||
                    ((state == MEM_WAIT) && !MEM_ready) ||
                    (state == ERROR);

    // Priority: reset default > freeze > taken branch > load-use > default.
    // A branch held across a freeze is only acted on (and counted) once the
    // freeze lifts.
    always_comb begin
        PC_enable      = 1'b1;
        IF_ID_enable   = 1'b1;
        ID_EX_enable   = 1'b1;
        EX_MEM_enable  = 1'b1;
        MEM_WB_enable  = 1'b1;
        IF_ID_flush    = 1'b0;
        ID_EX_flush    = 1'b0;
        branch_applied = 1'b0;
        if (reset) begin
            // hold default decoding while in reset
        end else if (freeze) begin
            PC_enable     = 1'b0;
            IF_ID_enable  = 1'b0;
            ID_EX_enable  = 1'b0;
            EX_MEM_enable = 1'b0;
            MEM_WB_enable = 1'b0;
        end else if (EX_branch_taken) begin
            IF_ID_flush    = 1'b1;
            ID_EX_flush    = 1'b1;
            branch_applied = 1'b1;
        end else if (stall) begin
            // Hold PC and IF/ID, insert a bubble into ID/EX.
            PC_enable    = 1'b0;
            IF_ID_enable = 1'b0;
            ID_EX_flush  = 1'b1;
        end
    end

    saturating_counter #(
        .WIDTH(COUNT_WIDTH)
    ) u_stall_cnt (
        .clock    (clock),
        .reset    (reset),
        .increment(!PC_enable),
        .count    (stall_cycles)
    );

    saturating_counter #(
        .WIDTH(COUNT_WIDTH)
    ) u_flush_cnt (
        .clock    (clock),
        .reset    (reset),
        .increment(branch_applied),
        .count    (flush_events)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; a separate monitor pops and compares each presented cycle.
// Enable/flush vector order: {PC, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
// IF_ID_flush, ID_EX_flush}. Counters/error are the values before the edge.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    localparam logic [6:0] NORM = 7'b11111_00;
    localparam logic [6:0] BR   = 7'b11111_11;
    localparam logic [6:0] LU   = 7'b00111_01;
    localparam logic [6:0] FRZ  = 7'b00000_00;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       EX_branch_taken = 1'b0;
    logic       MEM_request = 1'b0;
    logic       MEM_ready = 1'b0;
    logic       PC_enable, IF_ID_enable, ID_EX_enable, EX_MEM_enable, MEM_WB_enable;
    logic       IF_ID_flush, ID_EX_flush, error;
    logic [3:0] stall_cycles, flush_events;

    typedef struct packed {
        logic [15:0] idx;
        logic [6:0]  en;
        logic [3:0]  sc;
        logic [3:0]  fe;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    event issued;
    int   step_no = 0;
    int   tests   = 0;
    int   fails   = 0;

    pipeline_stall_controller #(
        .MEM_TIMEOUT(4),
        .COUNT_WIDTH(4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .EX_branch_taken(EX_branch_taken),
        .MEM_request    (MEM_request),
        .MEM_ready      (MEM_ready),
        .PC_enable      (PC_enable),
        .IF_ID_enable   (IF_ID_enable),
        .ID_EX_enable   (ID_EX_enable),
        .EX_MEM_enable  (EX_MEM_enable),
        .MEM_WB_enable  (MEM_WB_enable),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_flush    (ID_EX_flush),
        .error          (error),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
    );

    always #5 clock = ~clock;

    task automatic step(input logic r, input logic s, input logic b,
                        input logic q, input logic d, input logic [6:0] en,
                        input logic [3:0] sc, input logic [3:0] fe, input logic er);
        exp_t e;
        @(negedge clock);
        reset           = r;
        stall           = s;
        EX_branch_taken = b;
        MEM_request     = q;
        MEM_ready       = d;
        e.idx = 16'(step_no);
        e.en  = en;
        e.sc  = sc;
        e.fe  = fe;
        e.er  = er;
        exp_q.push_back(e);
        step_no++;
        -> issued;
    endtask

    // Monitor: compares the outputs presented 1 time unit after each issue.
    initial begin
        exp_t e;
        logic [6:0] act_en;
        forever begin
            @(issued);
            #1;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_empty: no expectation queued");
            end else begin
                e = exp_q.pop_front();
                act_en = {PC_enable, IF_ID_enable, ID_EX_enable, EX_MEM_enable,
                          MEM_WB_enable, IF_ID_flush, ID_EX_flush};
                tests++;
                if (act_en !== e.en) begin
                    fails++;
                    $display("FAIL step%0d enables/flushes: got %b expected %b", e.idx, act_en, e.en);
                end
                tests++;
                if (stall_cycles !== e.sc) begin
                    fails++;
                    $display("FAIL step%0d stall_cycles: got %0d expected %0d", e.idx, stall_cycles, e.sc);
                end
                tests++;
                if (flush_events !== e.fe) begin
                    fails++;
                    $display("FAIL step%0d flush_events: got %0d expected %0d", e.idx, flush_events, e.fe);
                end
                tests++;
                if (error !== e.er) begin
                    fails++;
                    $display("FAIL step%0d error: got %b expected %b", e.idx, error, e.er);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        //    r  s  b  q  d  en    sc  fe  er
        // reset default decode, even with a stall request pending
        step(1, 0, 0, 0, 0, NORM, 0, 0, 0);
        step(1, 1, 0, 0, 0, NORM, 0, 0, 0);
        step(0, 0, 0, 0, 0, NORM, 0, 0, 0);
        // single load-use stall
        step(0, 1, 0, 0, 0, LU,   0, 0, 0);
        step(0, 0, 0, 0, 0, NORM, 1, 0, 0);
        // branch coincident with stall: branch wins, stall dropped
        step(0, 1, 1, 0, 0, BR,   1, 0, 0);
        step(0, 0, 0, 0, 0, NORM, 1, 1, 0);
        step(0, 0, 1, 0, 0, BR,   1, 1, 0);
        step(0, 0, 0, 0, 0, NORM, 1, 2, 0);
        // 3-cycle memory wait, branch held across the freeze counted once
        step(0, 0, 0, 1, 0, FRZ,  1, 2, 0);
        step(0, 0, 1, 1, 0, FRZ,  2, 2, 0);
        step(0, 0, 1, 1, 0, FRZ,  3, 2, 0);
        step(0, 0, 1, 1, 1, BR,   4, 2, 0);
        step(0, 0, 0, 0, 0, NORM, 4, 3, 0);
        // back in RUN: a ready access does not freeze, a stall decodes normally
        step(0, 0, 0, 1, 1, NORM, 4, 3, 0);
        step(0, 1, 0, 0, 0, LU,   4, 3, 0);
        step(0, 0, 0, 0, 0, NORM, 5, 3, 0);

        // stall_cycles saturation at 15 over 20 stall cycles
        step(1, 0, 0, 0, 0, NORM, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0, 0, LU, (i > 15) ? 4'd15 : 4'(i), 0, 0);
        end
        step(0, 0, 0, 0, 0, NORM, 15, 0, 0);

        // flush_events saturation at 15 over 17 branches
        step(1, 0, 0, 0, 0, NORM, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 1, 0, 0, BR, 0, (i > 15) ? 4'd15 : 4'(i), 0);
        end
        step(0, 0, 0, 0, 0, NORM, 0, 15, 0);

        // asynchronous reset in the middle of MEM_WAIT
        step(1, 0, 0, 0, 0, NORM, 0, 0, 0);
        step(0, 0, 0, 1, 0, FRZ,  0, 0, 0);
        step(0, 0, 0, 1, 0, FRZ,  1, 0, 0);
        step(1, 0, 0, 1, 0, NORM, 0, 0, 0);
        step(0, 0, 0, 0, 0, NORM, 0, 0, 0);
        step(0, 0, 0, 1, 1, NORM, 0, 0, 0);

        // timeout (MEM_TIMEOUT=4): wait count 0..4 then ERROR, error a cycle later
        step(1, 0, 0, 0, 0, NORM, 0, 0, 0);
        step(0, 0, 0, 1, 0, FRZ,  0, 0, 0);
        step(0, 0, 0, 1, 0, FRZ,  1, 0, 0);
        step(0, 0, 0, 1, 0, FRZ,  2, 0, 0);
        step(0, 0, 0, 1, 0, FRZ,  3, 0, 0);
        step(0, 0, 0, 1, 0, FRZ,  4, 0, 0);
        step(0, 0, 0, 1, 0, FRZ,  5, 0, 0);
        step(0, 0, 0, 0, 0, FRZ,  6, 0, 0);
        // ERROR ignores ready, branch and stall
        step(0, 0, 1, 1, 1, FRZ,  7, 0, 1);
        step(0, 1, 0, 0, 1, FRZ,  8, 0, 1);
        step(0, 0, 0, 0, 0, FRZ,  9, 0, 1);
        step(1, 0, 0, 0, 0, NORM, 0, 0, 0);
        step(0, 0, 0, 0, 0, NORM, 0, 0, 0);
        step(0, 1, 0, 0, 0, LU,   0, 0, 0);

        @(negedge clock);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum cycles a data-memory access may wait before the error state.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32: width of the performance counters.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  load-use hazard request from the hazard detection unit.
REQ-006 EX_branch_taken  input  1  branch/jump resolved taken in execution stage.
REQ-007 MEM_request  input  1  memory stage issues a load or store this cycle.
REQ-008 MEM_ready  input  1  data memory completes the access this cycle.
REQ-009 PC_enable  output  1  program counter may update.
REQ-010 IF_ID_enable, ID_EX_enable, EX_MEM_enable, MEM_WB_enable  output  1 each  pipeline register may load.
REQ-011 IF_ID_flush, ID_EX_flush  output  1 each  pipeline register loads a bubble (NOP, all control zero).
REQ-012 error  output  1  memory timeout occurred; sticky until reset.
REQ-013 stall_cycles  output  COUNT_WIDTH  number of cycles with PC_enable low.
REQ-014 flush_events  output  COUNT_WIDTH  number of taken-branch flushes applied.

Function
REQ-015 SHALL implement FSM states RUN, MEM_WAIT, ERROR.
REQ-016 RUN -> MEM_WAIT when MEM_request=1 and MEM_ready=0; RUN stays RUN otherwise.
REQ-017 MEM_WAIT -> RUN on the cycle MEM_ready=1; MEM_WAIT -> ERROR when the wait counter reaches MEM_TIMEOUT with MEM_ready=0.
REQ-018 ERROR SHALL be left only by reset.
REQ-019 Wait counter SHALL clear on entry to MEM_WAIT and increment once per MEM_WAIT cycle.
REQ-020 Memory freeze (combinational): when (RUN and MEM_request=1 and MEM_ready=0) or in MEM_WAIT without MEM_ready, or in ERROR, all five enables SHALL be 0 and both flushes 0.
REQ-021 The cycle MEM_ready=1 in MEM_WAIT SHALL be treated as a normal RUN cycle for enable/flush decoding (zero added latency).
REQ-022 Taken branch (no freeze): PC_enable=1, IF_ID_flush=1, ID_EX_flush=1, all enables 1.
REQ-023 Load-use (no freeze, no branch): PC_enable=0, IF_ID_enable=0, ID_EX_flush=1, ID_EX_enable=1, EX_MEM_enable=1, MEM_WB_enable=1.
REQ-024 Priority SHALL be freeze > taken branch > load-use; a branch coincident with stall discards the stall.
REQ-025 Default (no event): all enables 1, all flushes 0.
REQ-026 Flush outputs SHALL never be 1 while the corresponding enable is 0.
REQ-027 stall_cycles SHALL increment each cycle PC_enable=0 (including ERROR), saturating at all-ones.
REQ-028 flush_events SHALL increment once per cycle in which REQ-022 applies, saturating at all-ones.
REQ-029 A branch held during a freeze SHALL be counted once, on the unfrozen cycle only.
REQ-030 error SHALL be registered: asserted the cycle after entering ERROR.

Reset
REQ-031 reset SHALL asynchronously force state RUN, wait counter 0, error 0, stall_cycles 0, flush_events 0.
REQ-032 During reset, enables SHALL be 1 and flushes 0 (RUN default decoding).
REQ-033 Reset asserted mid-MEM_WAIT or in ERROR SHALL abandon the access with no further counter updates.

Structure
REQ-034 State encodings (RUN=0, MEM_WAIT=1, ERROR=2) and MEM_TIMEOUT default SHALL live in the shared definitions include file.
REQ-035 One sub-module saturating_counter (parameter WIDTH; clock, reset, increment, count) SHALL be instantiated for stall_cycles and flush_events.
REQ-036 Enable/flush decode SHALL be purely combinational from state and inputs; only state, wait counter, error and counters are registered.

Verification
REQ-037 stall=1 for 1 cycle, no other event -> PC_enable=0, IF_ID_enable=0, ID_EX_flush=1; stall_cycles 0 -> 1.
REQ-038 EX_branch_taken=1 and stall=1 same cycle -> IF_ID_flush=1, ID_EX_flush=1, PC_enable=1; flush_events 0 -> 1, stall_cycles unchanged.
REQ-039 MEM_request=1, MEM_ready=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, state RUN on 4th, stall_cycles=3.
REQ-040 MEM_TIMEOUT=4, MEM_ready held 0 -> ERROR entered, error=1 next cycle, enables stay 0 until reset.
REQ-041 COUNT_WIDTH=4, 20 stall cycles -> stall_cycles saturates at 15.
REQ-042 reset asserted asynchronously during MEM_WAIT -> immediately state RUN, counters 0, all enables 1.
